// File: rtl/stage4_pkg.sv
// rtl/stage4_pkg.sv - shared widths, coefficient slicing and FSM encoding for stage4_horner
package stage4_pkg;

   localparam int COF_WIDTH  = 42;
   localparam int COF_FRAC   = 40;
   localparam int D_FRAC     = 32;
   localparam int DS_WIDTH   = D_FRAC + 2;
   localparam int PROD_WIDTH = COF_WIDTH + DS_WIDTH;
   localparam int PROD_FRAC  = COF_FRAC + D_FRAC;
   // Shift that returns a Q2.40 x Q1.32 product to Q2.40
   localparam int MAC_SHIFT  = PROD_FRAC - COF_FRAC;
   localparam int COF_BUS    = 4 * COF_WIDTH;

   localparam int C0_LO = 0;
   localparam int C1_LO = COF_WIDTH;
   localparam int C2_LO = 2 * COF_WIDTH;
   localparam int C3_LO = 3 * COF_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [COF_WIDTH-1:0] cof_slice(input logic [COF_BUS-1:0] cof, input int lo);
      return cof[lo +: COF_WIDTH];
   endfunction

endpackage

// File: rtl/horner_mac.sv
// rtl/horner_mac.sv - one Horner step: (acc * ds) >>> 32, truncated to the accumulator, plus coefficient
module horner_mac
   import stage4_pkg::*;
(
   input  logic signed [COF_WIDTH-1:0] acc,
   input  logic signed [DS_WIDTH-1:0]  ds,
   input  logic        [COF_WIDTH-1:0] cof,
   output logic        [COF_WIDTH-1:0] acc_next
);

   logic signed [PROD_WIDTH-1:0] prod;
   logic        [COF_WIDTH-1:0]  prod_sh;

   assign prod     = PROD_WIDTH'(acc) * PROD_WIDTH'(ds);
   // Wraps modulo 2^42; coefficient tables keep the true value in range
   assign prod_sh  = COF_WIDTH'(prod >>> MAC_SHIFT);
   assign acc_next = prod_sh + cof;

endmodule

// File: rtl/stage4_horner.sv
// rtl/stage4_horner.sv - iterative cubic Horner evaluator between fsincos stages 3 and 5
module stage4_horner
   import stage4_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 32,
   parameter int EXP_BIAS   = 127
)
(
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_sign_DorX,
   input  logic [EXP_WIDTH-1:0]  i_exp_DorX,
   input  logic [FRAC_WIDTH-1:0] i_frac_DorX,
   input  logic                  i_sel_DorX,
   input  logic                  i_X_ZERO_CAL,
   input  logic                  i_RESULT_SIGN_FLIP,
   input  logic                  i_COF_SIGN_REV_FLAG,
   input  logic                  i_sincos_proced,
   input  logic [COF_BUS-1:0]    i_COF,
   output logic                  o_st4_valid,
   output logic [COF_WIDTH-1:0]  o_st4_poly,
   output logic                  o_st4_sign,
   output logic [EXP_WIDTH-1:0]  o_st4_exp,
   output logic [FRAC_WIDTH-1:0] o_st4_frac,
   output logic                  o_st4_sel_DorX,
   output logic                  o_st4_X_ZERO_CAL,
   output logic                  o_st4_RESULT_SIGN_FLIP,
   output logic                  o_st4_sincos_proced
);

   state_t                state;
   logic [1:0]            step;
   logic [COF_WIDTH-1:0]  acc;
   logic [COF_WIDTH-1:0]  c2, c1, c0;
   logic [COF_WIDTH-1:0]  cof_sel;
   logic [COF_WIDTH-1:0]  acc_next;
   logic [DS_WIDTH-1:0]   ds;
   logic [DS_WIDTH-1:0]   ds_in;
   logic [EXP_WIDTH-1:0]  sh;
   logic [FRAC_WIDTH-1:0] dmag;

   logic                  arg_sign;
   logic [EXP_WIDTH-1:0]  arg_exp;
   logic [FRAC_WIDTH-1:0] arg_frac;
   logic                  arg_xz, arg_rsf, arg_sp;

   assign o_ready = (state == ST_IDLE);

   // Float argument to signed Q1.32; large exponents clamp to no shift
   always_comb begin
      sh    = '0;
      dmag  = '0;
      ds_in = '0;
      if (i_exp_DorX <= EXP_WIDTH'(EXP_BIAS - 1))
         sh = EXP_WIDTH'(EXP_BIAS - 1) - i_exp_DorX;
      if (sh < EXP_WIDTH'(FRAC_WIDTH))
         dmag = i_frac_DorX >> sh;
      ds_in = DS_WIDTH'(dmag);
      if (i_sign_DorX ^ i_COF_SIGN_REV_FLAG)
         ds_in = -DS_WIDTH'(dmag);
   end

   always_comb begin
      cof_sel = c0;
      case (step)
         2'd2:    cof_sel = c2;
         2'd1:    cof_sel = c1;
         default: cof_sel = c0;
      endcase
   end

   horner_mac u_mac (
      .acc      (acc),
      .ds       (ds),
      .cof      (cof_sel),
      .acc_next (acc_next)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state                  <= ST_IDLE;
         step                   <= '0;
         acc                    <= '0;
         c2                     <= '0;
         c1                     <= '0;
         c0                     <= '0;
         ds                     <= '0;
         arg_sign               <= 1'b0;
         arg_exp                <= '0;
         arg_frac               <= '0;
         arg_xz                 <= 1'b0;
         arg_rsf                <= 1'b0;
         arg_sp                 <= 1'b0;
         o_st4_valid            <= 1'b0;
         o_st4_poly             <= '0;
         o_st4_sign             <= 1'b0;
         o_st4_exp              <= '0;
         o_st4_frac             <= '0;
         o_st4_sel_DorX         <= 1'b0;
         o_st4_X_ZERO_CAL       <= 1'b0;
         o_st4_RESULT_SIGN_FLIP <= 1'b0;
         o_st4_sincos_proced    <= 1'b0;
      end else begin
         o_st4_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  if (i_sel_DorX) begin
                     acc      <= cof_slice(i_COF, C3_LO);
                     c2       <= cof_slice(i_COF, C2_LO);
                     c1       <= cof_slice(i_COF, C1_LO);
                     c0       <= cof_slice(i_COF, C0_LO);
                     ds       <= ds_in;
                     step     <= 2'd2;
                     arg_sign <= i_sign_DorX;
                     arg_exp  <= i_exp_DorX;
                     arg_frac <= i_frac_DorX;
                     arg_xz   <= i_X_ZERO_CAL;
                     arg_rsf  <= i_RESULT_SIGN_FLIP;
                     arg_sp   <= i_sincos_proced;
                     state    <= ST_MAC;
                  end else begin
                     // Bypass goes straight to DONE, so outputs load from the inputs here
                     acc                    <= '0;
                     o_st4_valid            <= 1'b1;
                     o_st4_poly             <= '0;
                     o_st4_sign             <= i_sign_DorX;
                     o_st4_exp              <= i_exp_DorX;
                     o_st4_frac             <= i_frac_DorX;
                     o_st4_sel_DorX         <= 1'b0;
                     o_st4_X_ZERO_CAL       <= i_X_ZERO_CAL;
                     o_st4_RESULT_SIGN_FLIP <= i_RESULT_SIGN_FLIP;
                     o_st4_sincos_proced    <= i_sincos_proced;
                     state                  <= ST_DONE;
                  end
               end
            end
            ST_MAC: begin
               acc <= acc_next;
               if (step == 2'd0) begin
                  o_st4_valid            <= 1'b1;
                  o_st4_poly             <= acc_next;
                  o_st4_sign             <= arg_sign;
                  o_st4_exp              <= arg_exp;
                  o_st4_frac             <= arg_frac;
                  o_st4_sel_DorX         <= 1'b1;
                  o_st4_X_ZERO_CAL       <= arg_xz;
                  o_st4_RESULT_SIGN_FLIP <= arg_rsf;
                  o_st4_sincos_proced    <= arg_sp;
                  state                  <= ST_DONE;
               end else begin
                  step <= step - 2'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage4_horner.sv
// tb/tb_stage4_horner.sv - scoreboard bench for stage4_horner with a reference polynomial model
module tb_stage4_horner;

   logic         clk;
   logic         rstn;
   logic         i_valid;
   logic         o_ready;
   logic         i_sign, i_sel, i_xz, i_rsf, i_rev, i_sp;
   logic [7:0]   i_exp;
   logic [31:0]  i_frac;
   logic [167:0] i_cof;
   logic         o_valid;
   logic [41:0]  o_poly;
   logic         o_sign, o_sel, o_xz, o_rsf, o_sp;
   logic [7:0]   o_exp;
   logic [31:0]  o_frac;

   typedef struct {
      logic [41:0] poly;
      logic [44:0] tag;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   localparam logic [41:0] ONE     = 42'h100_0000_0000;
   localparam logic [41:0] HALF    = 42'h080_0000_0000;
   localparam logic [41:0] NHALF   = 42'h380_0000_0000;
   localparam logic [41:0] P1875   = 42'h1E0_0000_0000;

   stage4_horner dut (
      .i_clk                  (clk),
      .i_rstn                 (rstn),
      .i_valid                (i_valid),
      .o_ready                (o_ready),
      .i_sign_DorX            (i_sign),
      .i_exp_DorX             (i_exp),
      .i_frac_DorX            (i_frac),
      .i_sel_DorX             (i_sel),
      .i_X_ZERO_CAL           (i_xz),
      .i_RESULT_SIGN_FLIP     (i_rsf),
      .i_COF_SIGN_REV_FLAG    (i_rev),
      .i_sincos_proced        (i_sp),
      .i_COF                  (i_cof),
      .o_st4_valid            (o_valid),
      .o_st4_poly             (o_poly),
      .o_st4_sign             (o_sign),
      .o_st4_exp              (o_exp),
      .o_st4_frac             (o_frac),
      .o_st4_sel_DorX         (o_sel),
      .o_st4_X_ZERO_CAL       (o_xz),
      .o_st4_RESULT_SIGN_FLIP (o_rsf),
      .o_st4_sincos_proced    (o_sp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // p(D) from the Horner recurrence using wide signed integers and floor scaling by 2^32
   function automatic logic [41:0] ref_poly(input logic [167:0] cof, input logic s, input logic [7:0] e,
                                            input logic [31:0] f, input logic rev);
      logic signed [127:0] c [4];
      logic signed [127:0] d, acc, t;
      logic signed [41:0]  w;
      logic [63:0]         dmag;
      int                  sh;
      for (int k = 0; k < 4; k++) begin
         w    = cof[k*42 +: 42];
         c[k] = w;
      end
      sh   = (e > 126) ? 0 : 126 - int'(e);
      dmag = (sh >= 32) ? 64'd0 : 64'(f) / (64'd1 << sh);
      d    = (s ^ rev) ? -128'(dmag) : 128'(dmag);
      acc  = c[3];
      for (int k = 2; k >= 0; k--) begin
         t   = acc * d;
         t   = t >>> 32;
         t   = t + c[k];
         w   = t[41:0];
         acc = w;
      end
      return acc[41:0];
   endfunction

   always @(negedge clk) begin
      if (o_valid) begin
         check("ready_during_done", 64'(o_ready), 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(o_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("poly", 64'(o_poly), 64'(e.poly));
            check("arg_flags", 64'({o_sign, o_exp, o_frac, o_sel, o_xz, o_rsf, o_sp}), 64'(e.tag));
            check("latency", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic send(input logic [167:0] cof, input logic s, input logic [7:0] e, input logic [31:0] f,
                       input logic sel, input logic rev, input logic xz, input logic rsf, input logic sp,
                       input logic [41:0] exp_poly, input bit push, input bit hold, output int acc_cyc);
      int   n;
      exp_t x;
      @(negedge clk);
      i_cof = cof; i_sign = s; i_exp = e; i_frac = f; i_sel = sel;
      i_rev = rev; i_xz = xz; i_rsf = rsf; i_sp = sp; i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         check("accept_timeout", 64'(o_ready), 64'd1);
         i_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      acc_cyc = cyc + 1;
      if (push) begin
         x.poly = sel ? exp_poly : 42'd0;
         x.tag  = {s, e, f, sel, xz, rsf, sp};
         x.due  = cyc + (sel ? 4 : 1);
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      if (!hold) i_valid = 1'b0;
   endtask

   task automatic rand_case(input bit hold, input int sel_mode, output int acc_cyc);
      logic [191:0] r;
      logic [7:0]   e;
      logic [31:0]  f;
      logic         s, rev, sel;
      r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      e   = 8'($urandom_range(88, 132));
      f   = {1'b1, 31'($urandom)};
      s   = 1'($urandom);
      rev = 1'($urandom);
      sel = (sel_mode == 2) ? 1'($urandom) : 1'(sel_mode);
      send(r[167:0], s, e, f, sel, rev, 1'($urandom), 1'($urandom), 1'($urandom),
           ref_poly(r[167:0], s, e, f, rev), 1'b1, hold, acc_cyc);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int ac, prev;
      rstn = 1'b0; i_valid = 1'b0; i_cof = '0; i_sign = 1'b0; i_exp = '0; i_frac = '0;
      i_sel = 1'b0; i_rev = 1'b0; i_xz = 1'b0; i_rsf = 1'b0; i_sp = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_outs", 64'({o_poly, o_sel, o_xz, o_rsf, o_sp}), 64'd0);
      check("rst_arg", 64'({o_sign, o_exp, o_frac}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(o_ready), 64'd1);

      send({42'd0, 42'd0, 42'd0, ONE}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ONE, 1'b1, 1'b0, ac);
      send({42'd0, 42'd0, ONE, 42'd0}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, HALF, 1'b1, 1'b0, ac);
      send({42'd0, 42'd0, ONE, 42'd0}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, NHALF, 1'b1, 1'b0, ac);
      send({ONE, ONE, ONE, ONE}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P1875, 1'b1, 1'b0, ac);
      send({ONE, ONE, ONE, ONE}, 1'b1, 8'd94, 32'hC000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ONE, 1'b1, 1'b0, ac);
      send({42'h155_5555_5555, 42'h2AA_AAAA_AAAA, ONE, ONE}, 1'b1, 8'd140, 32'hDEAD_BEEF, 1'b0, 1'b1,
           1'b1, 1'b0, 1'b1, 42'd0, 1'b1, 1'b0, ac);
      drain();

      // Back-to-back polynomial samples with i_valid never dropping
      prev = -1;
      for (int i = 0; i < 6; i++) begin
         rand_case(1'b1, 1, ac);
         if (prev >= 0) check("poly_spacing", 64'(ac - prev), 64'd5);
         prev = ac;
      end
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         rand_case(1'b1, 0, ac);
         if (prev >= 0) check("bypass_spacing", 64'(ac - prev), 64'd2);
         prev = ac;
      end
      i_valid = 1'b0;
      drain();

      // Reset while the second MAC step is in flight: sample must vanish
      send({ONE, ONE, ONE, ONE}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, P1875, 1'b0, 1'b0, ac);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_ready", 64'(o_ready), 64'd1);
      check("midrst_valid", 64'(o_valid), 64'd0);
      check("midrst_outs", 64'({o_poly, o_sel, o_xz, o_rsf, o_sp}), 64'd0);
      check("midrst_arg", 64'({o_sign, o_exp, o_frac}), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      send({ONE, ONE, ONE, ONE}, 1'b0, 8'd126, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, P1875, 1'b1, 1'b0, ac);
      drain();

      for (int i = 0; i < 40; i++) rand_case(1'($urandom), 2, ac);
      i_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
